wb_cp0: RTL and testbench
=========================

# wb_cp0

Parametrised write-back stage for the 5-stage MIPS pipeline. It commits results to the register file and HI/LO, and hosts an extended CP0: Status, Cause, EPC, BadVAddr, Count and Compare. It prioritises precise exceptions from seven sources: Int, AdEL, AdES, Sys, Bp, RI and Ov. It drives the redirect/cancel bus back to IF.

## Interface
Parameters:
- `EXC_ENTER_ADDR`, 32'h0000_0000, exception entry PC for every non-eret redirect.
- `NUM_HW_INT`, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+i].
- `COUNT_DIV`, 2, Count increments once every COUNT_DIV cycles (≥1).

Ports (clock and reset first):
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `WB_valid`  in  1  instruction in WB valid.
- `wen`/`wdest`  in  1/5  GPR write request and destination.
- `mem_result`/`lo_result`  in  32/32  result, HI/CP0 write data / LO write data.
- `hi_write`, `lo_write`, `mfhi`, `mflo`, `mtc0`, `mfc0`  in  1 each  op flags.
- `cp0r_addr`  in  8  {reg[4:0], sel[2:0]}.
- `syscall`, `brk`, `eret`, `ri`, `ov`, `adel`, `ades`  in  1 each  exception/return flags.
- `bad_vaddr`  in  32  faulting address for AdEL/AdES.
- `in_delay_slot`  in  1  instruction is in a branch delay slot.
- `pc`  in  32  instruction PC.
- `hw_int`  in  NUM_HW_INT  level-sensitive external interrupts.
- `rf_wen`, `rf_wdest`, `rf_wdata`  out  1/5/32  register file write.
- `WB_over`  out  1  equals WB_valid.
- `WB_wdest`  out  5  rf_wdest masked by WB_valid.
- `exc_bus`  out  33  {exc_valid, exc_pc}.
- `cancel`  out  1  flush younger stages.
- `timer_int`  out  1  Cause.TI.
- `WB_pc`, `HI_data`, `LO_data`  out  32 each  display.

## Operation
- **Interrupt pending:** int_req = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- **Cause.IP:**
  - IP[1:0] are software bits, mtc0-writable.
  - IP[2+i] is the registered hw_int[i].
  - IP7 additionally ORs TI.
  - Unmapped bits read 0.
- **Exception taken:** exc_taken = WB_valid & (int_req | adel | ri | ov | syscall | brk | ades).
- **Priority and ExcCode:**
  - Int 0
  - AdEL 4
  - RI 10
  - Ov 12
  - Sys 8
  - Bp 9
  - AdES 5
- **On exc_taken:**
  - Suppress rf_wen, HI/LO writes and mtc0.
  - Set EXL=1 and write ExcCode.
  - Cause.BD = in_delay_slot.
  - EPC = in_delay_slot ? pc−4 : pc.
  - BadVAddr = bad_vaddr for AdEL/AdES only.
  - exc_pc = EXC_ENTER_ADDR.
- **eret** (when WB_valid, not excepting):
  - EXL cleared.
  - exc_pc = EPC.
- **Redirect:** exc_valid = exc_taken | (eret & WB_valid); cancel = exc_valid.
- **Writable registers:**
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - EPC.
  - Count.
  - Compare.
  - BadVAddr is read-only.
  - Other addresses: writes ignored, reads 0.
- **Timer:**
  - TI sets when Count==Compare.
  - An mtc0 to Compare clears TI.
- **rf_wdata:** priority mfhi > mflo > mfc0 > mem_result.

## Timing
- exc_bus, cancel and rf_* are combinational in the WB cycle.
- All state updates on the next posedge.
- mfc0 returns the pre-edge value.
- hw_int has one register stage, so an interrupt is visible one cycle after assertion.
- **Reset values:**
  - hi, lo, EPC, BadVAddr, Count, Cause all 0.
  - Status 0.
  - Compare 32'hFFFF_FFFF.
  - TI 0.
  - Divider phase 0.
  - timer_int 0.
- **Simultaneous events:**
  - mtc0 Compare on the match cycle: write wins, TI stays 0.
  - mtc0 Count with an increment due: write wins, divider phase resets to 0.
  - mtc0 Status.IE=1 with a request pending: the interrupt is taken on the next valid WB instruction, never on the mtc0 itself.
  - Exception and eret together: the exception wins.
- Count wraps FFFF_FFFF→0 with no flag.
- TI is level: it stays set until a Compare write.
- An async reset mid-exception clears all state immediately. exc_bus reads {0, EXC_ENTER_ADDR} while reset is held, because exc_valid is 0.

## Structure
- Package `cp0_pkg` holds:
  - CP0 addresses {reg, sel}: 8, 9, 11, 12, 13, 14.
  - ExcCode constants.
  - Status/Cause field bit positions.
- Sub-module `cp0_timer` holds Count, the divider, Compare and TI. It exposes write strobes and read data.

## Test plan
- Reset, then mfc0 Compare → rf_wdata 32'hFFFF_FFFF. Status reads 0, timer_int 0.
- syscall at pc 0x100, not in a delay slot:
  - exc_bus = {1, EXC_ENTER_ADDR}, cancel 1, rf_wen 0.
  - EPC 0x100, Cause ExcCode 8, EXL 1.
  - A following eret gives exc_bus = {1, 0x100} and EXL 0.
- ov and syscall together, in a delay slot at pc 0x204 → ExcCode 12, EPC 0x200, BD 1, GPR not written.
- Status = 0x0000_8001 (IM7, IE), Compare = 10, COUNT_DIV = 2 → TI sets after ~20 cycles. The next valid instruction takes Int (ExcCode 0); a Compare write clears TI.
- hw_int[0] pulses while EXL=1 → no exception. After eret, with IM2 and IE set and hw_int[0] still high, the next instruction is interrupted.
- adel with bad_vaddr 0x1003 → BadVAddr 0x1003, ExcCode 4. Assert resetn low mid-sequence → all CP0 state returns to reset values asynchronously.

Source files
------------

// File: rtl/cp0_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cp0_pkg : CP0 register addresses, ExcCodes and field positions   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package cp0_pkg;

   localparam logic [7:0] c_ADDR_BADVADDR = {5'd8,  3'd0};
   localparam logic [7:0] c_ADDR_COUNT    = {5'd9,  3'd0};
   localparam logic [7:0] c_ADDR_COMPARE  = {5'd11, 3'd0};
   localparam logic [7:0] c_ADDR_STATUS   = {5'd12, 3'd0};
   localparam logic [7:0] c_ADDR_CAUSE    = {5'd13, 3'd0};
   localparam logic [7:0] c_ADDR_EPC      = {5'd14, 3'd0};

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   localparam int c_ST_IE  = 0;
   localparam int c_ST_EXL = 1;
   localparam int c_ST_IM  = 8;
   localparam int c_CA_EXC = 2;
   localparam int c_CA_IP  = 8;
   localparam int c_CA_TI  = 30;
   localparam int c_CA_BD  = 31;

   // Delay-slot faults restart at the branch, one word back.
   function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic ds);
      return ds ? (pc - 32'd4) : pc;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cp0_timer : Count/Compare timer with prescaler and level TI      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_we_i,
   input  logic        compare_we_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        ti_o
);

   localparam int              c_PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [c_PW-1:0] c_PHASE_LAST = c_PW'(COUNT_DIV - 1);

   logic [c_PW-1:0] phase_q, phase_d;
   logic [31:0]     count_q, count_d;
   logic [31:0]     compare_q, compare_d;
   logic            ti_q, ti_d;
   logic            w_tick;

   always_comb begin
      w_tick    = (phase_q == c_PHASE_LAST);
      phase_d   = w_tick ? '0 : phase_q + 1'b1;
      count_d   = w_tick ? count_q + 32'd1 : count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      // A software write to Count restarts the prescaler too.
      if (count_we_i) begin
         count_d = wdata_i;
         phase_d = '0;
      end
      if (compare_we_i) begin
         compare_d = wdata_i;
         ti_d      = 1'b0;
      end else if (count_q == compare_q) begin
         ti_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         phase_q   <= '0;
         count_q   <= 32'd0;
         compare_q <= 32'hFFFF_FFFF;
         ti_q      <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ti_o      = ti_q;

endmodule
`default_nettype wire

// File: rtl/wb_cp0.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_cp0 : MIPS write-back stage with CP0 and precise exceptions   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module wb_cp0
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_ENTER_ADDR = 32'h0000_0000,
   parameter int          NUM_HW_INT     = 6,
   parameter int          COUNT_DIV      = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  WB_valid,
   input  logic                  wen,
   input  logic [4:0]            wdest,
   input  logic [31:0]           mem_result,
   input  logic [31:0]           lo_result,
   input  logic                  hi_write,
   input  logic                  lo_write,
   input  logic                  mfhi,
   input  logic                  mflo,
   input  logic                  mtc0,
   input  logic                  mfc0,
   input  logic [7:0]            cp0r_addr,
   input  logic                  syscall,
   input  logic                  brk,
   input  logic                  eret,
   input  logic                  ri,
   input  logic                  ov,
   input  logic                  adel,
   input  logic                  ades,
   input  logic [31:0]           bad_vaddr,
   input  logic                  in_delay_slot,
   input  logic [31:0]           pc,
   input  logic [NUM_HW_INT-1:0] hw_int,
   output logic                  rf_wen,
   output logic [4:0]            rf_wdest,
   output logic [31:0]           rf_wdata,
   output logic                  WB_over,
   output logic [4:0]            WB_wdest,
   output logic [32:0]           exc_bus,
   output logic                  cancel,
   output logic                  timer_int,
   output logic [31:0]           WB_pc,
   output logic [31:0]           HI_data,
   output logic [31:0]           LO_data
);

   logic [NUM_HW_INT-1:0] hw_int_q;
   logic [31:0]           hi_q, hi_d, lo_q, lo_d;
   logic [31:0]           epc_q, epc_d, badvaddr_q, badvaddr_d;
   logic [7:0]            im_q, im_d;
   logic                  exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
   logic [4:0]            exccode_q, exccode_d;
   logic [1:0]            ipsw_q, ipsw_d;

   logic [5:0]  w_ip_hw;
   logic [7:0]  w_ip;
   logic        w_valid, w_int_req, w_exc_any, w_exc_taken, w_eret_go, w_commit;
   logic        w_mtc0, w_exc_valid, w_count_we, w_compare_we, w_ti;
   exc_code_e   w_exc_code;
   logic [31:0] w_count, w_compare, w_status, w_cause, w_cp0_rdata;

   for (genvar gi = 0; gi < 6; gi++) begin : g_ip
      if (gi < NUM_HW_INT) begin : g_map
         assign w_ip_hw[gi] = hw_int_q[gi];
      end else begin : g_none
         assign w_ip_hw[gi] = 1'b0;
      end
   end

   assign w_ip      = {w_ip_hw[5] | w_ti, w_ip_hw[4:0], ipsw_q};
   assign w_int_req = ie_q & ~exl_q & |(w_ip & im_q);
   // Holding reset must never produce a redirect, whatever WB_valid does.
   assign w_valid   = WB_valid & resetn;

   always_comb begin
      w_exc_any  = 1'b1;
      w_exc_code = EXC_INT;
      if      (w_int_req) w_exc_code = EXC_INT;
      else if (adel)      w_exc_code = EXC_ADEL;
      else if (ri)        w_exc_code = EXC_RI;
      else if (ov)        w_exc_code = EXC_OV;
      else if (syscall)   w_exc_code = EXC_SYS;
      else if (brk)       w_exc_code = EXC_BP;
      else if (ades)      w_exc_code = EXC_ADES;
      else                w_exc_any  = 1'b0;
   end

   assign w_exc_taken  = w_valid & w_exc_any;
   assign w_eret_go    = w_valid & eret & ~w_exc_taken;
   assign w_commit     = w_valid & ~w_exc_taken;
   assign w_mtc0       = w_commit & mtc0;
   assign w_count_we   = w_mtc0 & (cp0r_addr == c_ADDR_COUNT);
   assign w_compare_we = w_mtc0 & (cp0r_addr == c_ADDR_COMPARE);

   cp0_timer #(
      .COUNT_DIV    (COUNT_DIV)
   ) u_timer (
      .clk          (clk),
      .resetn       (resetn),
      .count_we_i   (w_count_we),
      .compare_we_i (w_compare_we),
      .wdata_i      (mem_result),
      .count_o      (w_count),
      .compare_o    (w_compare),
      .ti_o         (w_ti)
   );

   always_comb begin
      w_status                   = 32'd0;
      w_status[c_ST_IM +: 8]     = im_q;
      w_status[c_ST_EXL]         = exl_q;
      w_status[c_ST_IE]          = ie_q;
      w_cause                    = 32'd0;
      w_cause[c_CA_BD]           = bd_q;
      w_cause[c_CA_TI]           = w_ti;
      w_cause[c_CA_IP +: 8]      = w_ip;
      w_cause[c_CA_EXC +: 5]     = exccode_q;
      case (cp0r_addr)
         c_ADDR_BADVADDR: w_cp0_rdata = badvaddr_q;
         c_ADDR_COUNT:    w_cp0_rdata = w_count;
         c_ADDR_COMPARE:  w_cp0_rdata = w_compare;
         c_ADDR_STATUS:   w_cp0_rdata = w_status;
         c_ADDR_CAUSE:    w_cp0_rdata = w_cause;
         c_ADDR_EPC:      w_cp0_rdata = epc_q;
         default:         w_cp0_rdata = 32'd0;
      endcase
   end

   always_comb begin
      if      (mfhi) rf_wdata = hi_q;
      else if (mflo) rf_wdata = lo_q;
      else if (mfc0) rf_wdata = w_cp0_rdata;
      else           rf_wdata = mem_result;
   end

   assign rf_wen      = w_commit & wen;
   assign rf_wdest    = wdest;
   assign WB_over     = WB_valid;
   assign WB_wdest    = WB_valid ? wdest : 5'd0;
   assign w_exc_valid = w_exc_taken | w_eret_go;
   assign exc_bus     = {w_exc_valid, w_eret_go ? epc_q : EXC_ENTER_ADDR};
   assign cancel      = w_exc_valid;
   assign timer_int   = w_ti;
   assign WB_pc       = pc;
   assign HI_data     = hi_q;
   assign LO_data     = lo_q;

   always_comb begin
      hi_d       = hi_q;
      lo_d       = lo_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      exccode_d  = exccode_q;
      ipsw_d     = ipsw_q;
      if (w_exc_taken) begin
         exl_d     = 1'b1;
         exccode_d = w_exc_code;
         bd_d      = in_delay_slot;
         epc_d     = epc_of(pc, in_delay_slot);
         if (w_exc_code == EXC_ADEL || w_exc_code == EXC_ADES)
            badvaddr_d = bad_vaddr;
      end else if (w_commit) begin
         if (hi_write) hi_d = mem_result;
         if (lo_write) lo_d = lo_result;
         if (w_mtc0) begin
            case (cp0r_addr)
               c_ADDR_STATUS: begin
                  im_d  = mem_result[c_ST_IM +: 8];
                  exl_d = mem_result[c_ST_EXL];
                  ie_d  = mem_result[c_ST_IE];
               end
               c_ADDR_CAUSE: ipsw_d = mem_result[c_CA_IP +: 2];
               c_ADDR_EPC:   epc_d  = mem_result;
               default: ;
            endcase
         end
         if (eret) exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hw_int_q   <= '0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         epc_q      <= 32'd0;
         badvaddr_q <= 32'd0;
         im_q       <= 8'd0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         exccode_q  <= 5'd0;
         ipsw_q     <= 2'd0;
      end else begin
         hw_int_q   <= hw_int;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         exccode_q  <= exccode_d;
         ipsw_q     <= ipsw_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_cp0.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wb_cp0 : directed table, corner sequences and random vs model |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_wb_cp0;

   localparam logic [31:0] ENTER = 32'hBFC0_0380;
   localparam int          DIV   = 2;
   localparam bit [6:0] F_SYS = 7'h01, F_BRK = 7'h02, F_ERET = 7'h04, F_RI = 7'h08,
                        F_OV  = 7'h10, F_ADEL = 7'h20, F_ADES = 7'h40;
   localparam bit [7:0] A_BVA = 8'h40, A_CNT = 8'h48, A_CMP = 8'h58,
                        A_ST  = 8'h60, A_CA  = 8'h68, A_EPC = 8'h70;

   typedef struct {
      bit valid, wen; bit [4:0] wdest; bit [31:0] mres, lores;
      bit hiw, low, mfhi, mflo, mtc0, mfc0; bit [7:0] addr;
      bit sys, brk, eret, ri, ov, adel, ades; bit [31:0] bva, pc; bit ds; bit [5:0] hw;
   } in_t;
   typedef struct { in_t i; bit ev; bit [31:0] epc; bit wen; bit [31:0] wd; } vec_t;

   logic clk = 1'b0, resetn = 1'b0;
   logic WB_valid, wen, hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
   logic syscall, brk, eret, ri, ov, adel, ades, in_delay_slot;
   logic [4:0] wdest, rf_wdest, WB_wdest;
   logic [31:0] mem_result, lo_result, bad_vaddr, pc, rf_wdata, WB_pc, HI_data, LO_data;
   logic [7:0] cp0r_addr;
   logic [5:0] hw_int;
   logic rf_wen, WB_over, cancel, timer_int;
   logic [32:0] exc_bus;

   int n_vec = 0, n_err = 0;

   wb_cp0 #(.EXC_ENTER_ADDR(ENTER), .NUM_HW_INT(6), .COUNT_DIV(DIV)) dut (
      .clk(clk), .resetn(resetn), .WB_valid(WB_valid), .wen(wen), .wdest(wdest),
      .mem_result(mem_result), .lo_result(lo_result), .hi_write(hi_write), .lo_write(lo_write),
      .mfhi(mfhi), .mflo(mflo), .mtc0(mtc0), .mfc0(mfc0), .cp0r_addr(cp0r_addr),
      .syscall(syscall), .brk(brk), .eret(eret), .ri(ri), .ov(ov), .adel(adel), .ades(ades),
      .bad_vaddr(bad_vaddr), .in_delay_slot(in_delay_slot), .pc(pc), .hw_int(hw_int),
      .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_over(WB_over),
      .WB_wdest(WB_wdest), .exc_bus(exc_bus), .cancel(cancel), .timer_int(timer_int),
      .WB_pc(WB_pc), .HI_data(HI_data), .LO_data(LO_data));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // ---------------- reference model: architectural state ----------------
   bit [31:0] m_hi, m_lo, m_epc, m_bva, m_cbase, m_compare;
   int        m_cyc;
   bit [7:0]  m_im;
   bit        m_exl, m_ie, m_bd, m_ti;
   bit [4:0]  m_code;
   bit [1:0]  m_ipsw;
   bit [5:0]  m_hw;

   task automatic model_reset();
      m_hi = 0; m_lo = 0; m_epc = 0; m_bva = 0; m_cbase = 0; m_cyc = 0;
      m_compare = 32'hFFFF_FFFF; m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0;
      m_ti = 0; m_code = 0; m_ipsw = 0; m_hw = 0;
   endtask

   function automatic bit [31:0] m_count();
      return m_cbase + 32'(m_cyc / DIV);
   endfunction

   function automatic bit [7:0] m_ip();
      return {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
   endfunction

   function automatic bit [31:0] m_read(input bit [7:0] a);
      case (a)
         A_BVA:   return m_bva;
         A_CNT:   return m_count();
         A_CMP:   return m_compare;
         A_ST:    return {16'd0, m_im, 6'd0, m_exl, m_ie};
         A_CA:    return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
         A_EPC:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   // Highest-priority asserted source wins: Int, AdEL, RI, Ov, Sys, Bp, AdES.
   function automatic void pick(input in_t i, output bit any, output bit [4:0] code);
      bit       fl[7];
      bit [4:0] cd[7];
      fl = '{m_ie & ~m_exl & (|(m_ip() & m_im)), i.adel, i.ri, i.ov, i.sys, i.brk, i.ades};
      cd = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd5};
      any = 0; code = 0;
      for (int k = 6; k >= 0; k--) if (fl[k]) begin any = 1; code = cd[k]; end
      any = any & i.valid;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input in_t i);
      WB_valid = i.valid; wen = i.wen; wdest = i.wdest; mem_result = i.mres;
      lo_result = i.lores; hi_write = i.hiw; lo_write = i.low; mfhi = i.mfhi;
      mflo = i.mflo; mtc0 = i.mtc0; mfc0 = i.mfc0; cp0r_addr = i.addr;
      syscall = i.sys; brk = i.brk; eret = i.eret; ri = i.ri; ov = i.ov;
      adel = i.adel; ades = i.ades; bad_vaddr = i.bva; in_delay_slot = i.ds;
      pc = i.pc; hw_int = i.hw;
   endtask

   task automatic model_chk(input in_t i);
      bit any, eg; bit [4:0] code; bit [31:0] wd;
      pick(i, any, code);
      eg = i.valid & i.eret & ~any;
      wd = i.mfhi ? m_hi : i.mflo ? m_lo : i.mfc0 ? m_read(i.addr) : i.mres;
      chk("exc_bus",   exc_bus,   {any | eg, eg ? m_epc : ENTER});
      chk("cancel",    cancel,    any | eg);
      chk("rf_wen",    rf_wen,    i.valid & i.wen & ~any);
      chk("rf_wdata",  rf_wdata,  wd);
      chk("rf_wdest",  rf_wdest,  i.wdest);
      chk("WB_wdest",  WB_wdest,  i.valid ? i.wdest : 5'd0);
      chk("WB_over",   WB_over,   i.valid);
      chk("WB_pc",     WB_pc,     i.pc);
      chk("timer_int", timer_int, m_ti);
      chk("HI_data",   HI_data,   m_hi);
      chk("LO_data",   LO_data,   m_lo);
   endtask

   task automatic model_update(input in_t i);
      bit any, commit, wr; bit [4:0] code; bit [31:0] cnt;
      pick(i, any, code);
      cnt    = m_count();
      commit = i.valid & ~any;
      wr     = commit & i.mtc0;
      if (wr && i.addr == A_CMP) m_ti = 0;
      else if (cnt == m_compare) m_ti = 1;
      if (wr && i.addr == A_CNT) begin m_cbase = i.mres; m_cyc = 0; end
      else m_cyc++;
      if (wr && i.addr == A_CMP) m_compare = i.mres;
      if (any) begin
         m_exl = 1; m_code = code; m_bd = i.ds;
         m_epc = i.ds ? i.pc - 32'd4 : i.pc;
         if (code == 5'd4 || code == 5'd5) m_bva = i.bva;
      end else if (commit) begin
         if (i.hiw) m_hi = i.mres;
         if (i.low) m_lo = i.lores;
         if (wr && i.addr == A_ST) begin m_im = i.mres[15:8]; m_exl = i.mres[1]; m_ie = i.mres[0]; end
         if (wr && i.addr == A_CA)  m_ipsw = i.mres[9:8];
         if (wr && i.addr == A_EPC) m_epc = i.mres;
         if (i.eret) m_exl = 0;
      end
      m_hw = i.hw;
   endtask

   task automatic step(input in_t i);
      drive(i); #1; model_chk(i);
      @(posedge clk); model_update(i); @(negedge clk);
   endtask

   // ---------------- stimulus builders ----------------
   function automatic in_t nop(input bit [31:0] p);
      in_t t; t = '{default: '0}; t.valid = 1; t.pc = p; return t;
   endfunction
   function automatic in_t rd(input bit [7:0] a, input bit [31:0] p);
      in_t t; t = nop(p); t.mfc0 = 1; t.wen = 1; t.wdest = 5'd3; t.addr = a;
      t.mres = 32'h5A5A_0000; return t;
   endfunction
   function automatic in_t wr(input bit [7:0] a, input bit [31:0] d, input bit [31:0] p);
      in_t t; t = nop(p); t.mtc0 = 1; t.addr = a; t.mres = d; return t;
   endfunction
   function automatic in_t ex(input bit [31:0] p, input bit [6:0] f, input bit ds, input bit [31:0] bv);
      in_t t; t = nop(p); t.wdest = 5'd7; t.mres = 32'h1234; t.ds = ds; t.bva = bv;
      t.sys = f[0]; t.brk = f[1]; t.eret = f[2]; t.ri = f[3]; t.ov = f[4]; t.adel = f[5]; t.ades = f[6];
      t.wen = ~f[2]; return t;
   endfunction
   function automatic in_t hl(input bit hw_, lw, mh, ml, input bit [31:0] d, l);
      in_t t; t = nop(32'h900); t.hiw = hw_; t.low = lw; t.mfhi = mh; t.mflo = ml;
      t.mres = d; t.lores = l; t.wen = mh | ml; t.wdest = 5'd9; return t;
   endfunction
   function automatic vec_t mk(input in_t i, input bit ev, input bit [31:0] ep, input bit w, input bit [31:0] wd);
      vec_t v; v.i = i; v.ev = ev; v.epc = ep; v.wen = w; v.wd = wd; return v;
   endfunction

   initial begin
      vec_t tab[$];
      in_t  t;
      int   k;

      tab.push_back(mk(rd(A_CMP, 32'h10), 0, ENTER, 1, 32'hFFFF_FFFF));
      tab.push_back(mk(rd(A_ST,  32'h14), 0, ENTER, 1, 32'h0));
      tab.push_back(mk(rd(A_CA,  32'h18), 0, ENTER, 1, 32'h0));
      tab.push_back(mk(ex(32'h100, F_SYS, 0, 0), 1, ENTER, 0, 32'h1234));
      tab.push_back(mk(rd(A_EPC, 32'h20), 0, ENTER, 1, 32'h100));
      tab.push_back(mk(rd(A_CA,  32'h24), 0, ENTER, 1, 32'h20));
      tab.push_back(mk(rd(A_ST,  32'h28), 0, ENTER, 1, 32'h2));
      tab.push_back(mk(ex(32'h104, F_ERET, 0, 0), 1, 32'h100, 0, 32'h1234));
      tab.push_back(mk(rd(A_ST,  32'h2C), 0, ENTER, 1, 32'h0));
      tab.push_back(mk(ex(32'h204, F_OV | F_SYS, 1, 0), 1, ENTER, 0, 32'h1234));
      tab.push_back(mk(rd(A_CA,  32'h30), 0, ENTER, 1, 32'h8000_0030));
      tab.push_back(mk(rd(A_EPC, 32'h34), 0, ENTER, 1, 32'h200));
      tab.push_back(mk(ex(32'h208, F_ERET, 0, 0), 1, 32'h200, 0, 32'h1234));
      tab.push_back(mk(ex(32'h300, F_ADEL, 0, 32'h1003), 1, ENTER, 0, 32'h1234));
      tab.push_back(mk(rd(A_BVA, 32'h38), 0, ENTER, 1, 32'h1003));
      tab.push_back(mk(rd(A_CA,  32'h3C), 0, ENTER, 1, 32'h10));
      tab.push_back(mk(ex(32'h304, F_ERET, 0, 0), 1, 32'h300, 0, 32'h1234));
      t = ex(32'h308, F_SYS, 0, 0); t.valid = 0;
      tab.push_back(mk(t, 0, ENTER, 0, 32'h1234));
      tab.push_back(mk(wr(A_BVA, 32'hDEAD_BEEF, 32'h40), 0, ENTER, 0, 32'hDEAD_BEEF));
      tab.push_back(mk(rd(A_BVA, 32'h44), 0, ENTER, 1, 32'h1003));
      tab.push_back(mk(hl(1, 1, 0, 0, 32'hAAAA_5555, 32'h1234_5678), 0, ENTER, 0, 32'hAAAA_5555));
      tab.push_back(mk(hl(0, 0, 1, 0, 32'h1111, 0), 0, ENTER, 1, 32'hAAAA_5555));
      tab.push_back(mk(hl(0, 0, 0, 1, 32'h1111, 0), 0, ENTER, 1, 32'h1234_5678));
      tab.push_back(mk(hl(0, 0, 1, 1, 32'h1111, 0), 0, ENTER, 1, 32'hAAAA_5555));
      tab.push_back(mk(wr(8'h78, 32'hFFFF, 32'h48), 0, ENTER, 0, 32'hFFFF));
      tab.push_back(mk(rd(8'h78, 32'h4C), 0, ENTER, 1, 32'h0));
      tab.push_back(mk(ex(32'h400, F_ADES, 0, 32'h2002), 1, ENTER, 0, 32'h1234));
      tab.push_back(mk(rd(A_BVA, 32'h50), 0, ENTER, 1, 32'h2002));
      tab.push_back(mk(rd(A_CA,  32'h54), 0, ENTER, 1, 32'h14));
      tab.push_back(mk(ex(32'h404, F_ERET, 0, 0), 1, 32'h400, 0, 32'h1234));
      tab.push_back(mk(ex(32'h500, F_BRK | F_RI, 0, 0), 1, ENTER, 0, 32'h1234));
      tab.push_back(mk(rd(A_CA,  32'h58), 0, ENTER, 1, 32'h28));
      tab.push_back(mk(ex(32'h504, F_ERET, 0, 0), 1, 32'h500, 0, 32'h1234));
      tab.push_back(mk(ex(32'h600, F_SYS | F_ERET, 0, 0), 1, ENTER, 0, 32'h1234));
      tab.push_back(mk(rd(A_EPC, 32'h5C), 0, ENTER, 1, 32'h600));
      tab.push_back(mk(ex(32'h604, F_ERET, 0, 0), 1, 32'h600, 0, 32'h1234));

      t = nop(0); t.valid = 0; drive(t);
      repeat (2) @(negedge clk);
      resetn = 1; model_reset();

      foreach (tab[n]) begin
         drive(tab[n].i); #1; model_chk(tab[n].i);
         chk($sformatf("tab%0d.exc_valid", n), exc_bus[32], tab[n].ev);
         chk($sformatf("tab%0d.exc_pc", n), exc_bus[31:0], tab[n].epc);
         chk($sformatf("tab%0d.rf_wen", n), rf_wen, tab[n].wen);
         chk($sformatf("tab%0d.rf_wdata", n), rf_wdata, tab[n].wd);
         @(posedge clk); model_update(tab[n].i); @(negedge clk);
      end

      // Timer interrupt through IM7.
      step(wr(A_ST, 32'h8001, 32'h700));
      step(wr(A_CNT, 32'd0, 32'h704));
      step(wr(A_CMP, 32'd10, 32'h708));
      t = nop(0); t.valid = 0;
      k = 0;
      while (timer_int !== 1'b1 && k < 60) begin step(t); k++; end
      chk("ti_wait", timer_int, 1'b1);
      step(nop(32'h710));
      chk("int_taken_code", m_read(A_CA) & 32'h7C, 32'h0);
      step(rd(A_CA, 32'h714));
      drive(rd(A_CA, 32'h718)); #1;
      chk("cause_ti", rf_wdata, 32'h4000_8000);
      @(posedge clk); model_update(rd(A_CA, 32'h718)); @(negedge clk);
      step(wr(A_CMP, 32'd100000, 32'h71C));
      drive(nop(32'h720)); #1;
      chk("ti_cleared", timer_int, 1'b0);
      @(posedge clk); model_update(nop(32'h720)); @(negedge clk);
      step(wr(A_ST, 32'h0, 32'h724));

      // Compare write on the match cycle keeps TI low.
      step(wr(A_CNT, 32'd0, 32'h730));
      step(wr(A_CMP, 32'd4, 32'h734));
      t = nop(0); t.valid = 0;
      k = 0;
      while (m_count() != m_compare && k < 40) begin step(t); k++; end
      step(wr(A_CMP, 32'h1000, 32'h738));
      step(t);
      chk("ti_match_write", timer_int, 1'b0);
      // Count write when an increment is due: write wins, prescaler restarts.
      if (m_cyc % DIV == 0) step(t);
      step(wr(A_CNT, 32'h50, 32'h73C));
      drive(rd(A_CNT, 32'h740)); #1; chk("cnt_wr0", rf_wdata, 32'h50);
      @(posedge clk); model_update(rd(A_CNT, 32'h740)); @(negedge clk);
      drive(rd(A_CNT, 32'h744)); #1; chk("cnt_wr1", rf_wdata, 32'h50);
      @(posedge clk); model_update(rd(A_CNT, 32'h744)); @(negedge clk);
      drive(rd(A_CNT, 32'h748)); #1; chk("cnt_wr2", rf_wdata, 32'h51);
      @(posedge clk); model_update(rd(A_CNT, 32'h748)); @(negedge clk);

      // hw_int[0] while EXL, then after eret; mtc0 IE never interrupts itself.
      t = nop(32'h800); t.hw = 6'h1;
      step(t); step(t);
      t = wr(A_ST, 32'h0401, 32'h804); t.hw = 6'h1;
      drive(t); #1; chk("mtc0_ie_no_int", exc_bus[32], 1'b0);
      @(posedge clk); model_update(t); @(negedge clk);
      t = nop(32'h808); t.hw = 6'h1;
      drive(t); #1; chk("int_after_mtc0", exc_bus, {1'b1, ENTER});
      @(posedge clk); model_update(t); @(negedge clk);
      t = nop(32'h80C); t.hw = 6'h1;
      drive(t); #1; chk("no_int_in_exl", exc_bus[32], 1'b0);
      @(posedge clk); model_update(t); @(negedge clk);
      t = ex(32'h810, F_ERET, 0, 0); t.hw = 6'h1;
      drive(t); #1; chk("eret_pc", exc_bus, {1'b1, 32'h808});
      @(posedge clk); model_update(t); @(negedge clk);
      t = nop(32'h808); t.hw = 6'h1;
      drive(t); #1; chk("int_after_eret", exc_bus, {1'b1, ENTER});
      @(posedge clk); model_update(t); @(negedge clk);
      step(wr(A_ST, 32'h0, 32'h820));

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         bit [7:0] al[7];
         int r;
         al = '{A_BVA, A_CNT, A_CMP, A_ST, A_CA, A_EPC, 8'($urandom)};
         t = '{default: '0};
         t.valid = ($urandom_range(0, 9) != 0);
         t.pc = $urandom & 32'hFFFF_FFFC; t.wen = 1'($urandom); t.wdest = 5'($urandom);
         t.mres = $urandom; t.lores = $urandom; t.bva = $urandom;
         t.hiw = ($urandom_range(0, 9) == 0); t.low = ($urandom_range(0, 9) == 0);
         t.mfhi = ($urandom_range(0, 9) == 0); t.mflo = ($urandom_range(0, 9) == 0);
         r = $urandom_range(0, 99);
         if (r < 15) begin
            t.mtc0 = 1; t.addr = al[$urandom_range(0, 6)];
            if (t.addr == A_CMP && $urandom_range(0, 1) == 1) t.mres = m_count() + $urandom_range(0, 12);
         end else if (r < 35) begin
            t.mfc0 = 1; t.addr = al[$urandom_range(0, 6)];
         end else if (r < 40) begin
            t.eret = 1;
         end
         t.sys = ($urandom_range(0, 32) == 0); t.brk  = ($urandom_range(0, 32) == 0);
         t.ri  = ($urandom_range(0, 32) == 0); t.ov   = ($urandom_range(0, 32) == 0);
         t.adel = ($urandom_range(0, 32) == 0); t.ades = ($urandom_range(0, 32) == 0);
         t.ds = ($urandom_range(0, 2) == 0);
         t.hw = ($urandom_range(0, 19) == 0) ? 6'($urandom) : m_hw;
         step(t);
      end

      // Asynchronous reset in the middle of an exception sequence.
      step(ex(32'hA00, F_ADEL, 0, 32'h1003));
      drive(nop(32'hA04));
      #2 resetn = 0;
      #1;
      chk("rst_exc_bus", exc_bus, {1'b0, ENTER});
      chk("rst_cancel", cancel, 1'b0);
      chk("rst_hi", HI_data, 32'h0);
      chk("rst_ti", timer_int, 1'b0);
      @(posedge clk); @(negedge clk);
      resetn = 1; model_reset();
      drive(rd(A_BVA, 32'hA08)); #1; chk("rst_bva", rf_wdata, 32'h0);
      @(posedge clk); model_update(rd(A_BVA, 32'hA08)); @(negedge clk);
      drive(rd(A_CMP, 32'hA0C)); #1; chk("rst_cmp", rf_wdata, 32'hFFFF_FFFF);
      @(posedge clk); model_update(rd(A_CMP, 32'hA0C)); @(negedge clk);
      drive(rd(A_ST, 32'hA10)); #1; chk("rst_status", rf_wdata, 32'h0);
      @(posedge clk); model_update(rd(A_ST, 32'hA10)); @(negedge clk);
      drive(rd(A_CA, 32'hA14)); #1; chk("rst_cause", rf_wdata, 32'h0);
      @(posedge clk); model_update(rd(A_CA, 32'hA14)); @(negedge clk);
      drive(rd(A_EPC, 32'hA18)); #1; chk("rst_epc", rf_wdata, 32'h0);
      @(posedge clk); model_update(rd(A_EPC, 32'hA18)); @(negedge clk);
      step(rd(A_CNT, 32'hA1C));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
